// File: rtl/stn_pkg.sv
// Shared definitions for the STN panel transmit path: FSM encoding,
// interface widths and a small counter-width helper.
package stn_pkg;

   localparam int STN_DAT_W  = 4;
   localparam int RAM_ADDR_W = 13;
   localparam int RAM_BYTES  = 6144;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREFETCH = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_HBLANK   = 2'd3
   } stn_state_e;

   // Bits needed for a counter holding 0..n-1 (never less than 1).
   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stn_shift_timer.sv
// Shift-period timer: phase counter (0..2*DIV-1), period index and the
// stn_fpshift waveform. The parent restarts it on every FSM state entry.
module stn_shift_timer
   import stn_pkg::*;
#(
   parameter int DIV    = 4,
   parameter int PH_W   = 3,
   parameter int PIDX_W = 7
)(
   input  logic              clk,
   input  logic              rst_x,
   input  logic              i_clr,
   input  logic              i_shift_en,
   output logic [PH_W-1:0]   o_ph,
   output logic              o_tick,
   output logic [PIDX_W-1:0] o_pidx,
   output logic              o_fpshift
);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2*DIV-1);
   localparam logic [PH_W-1:0] PH_RISE = PH_W'(1);
   localparam logic [PH_W-1:0] PH_FALL = PH_W'(DIV);

   logic [PH_W-1:0]   r_ph;
   logic [PIDX_W-1:0] r_pidx;
   logic              w_tick;

   // Last clock of the current shift period.
   assign w_tick = (r_ph == PH_LAST);

   // Phase counter wraps once per shift period and advances the period index.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      if (!rst_x) begin
         r_ph   <= '0;
         r_pidx <= '0;
      end else if (i_clr) begin
         r_ph   <= '0;
         r_pidx <= '0;
      end else if (w_tick) begin
         r_ph   <= '0;
         r_pidx <= r_pidx + 1'b1;
      end else begin
         r_ph   <= r_ph + 1'b1;
      end
   end

   // Shift clock is high for ph 1..DIV: one clock of data setup before the
   // rise, DIV-1 clocks of hold after the fall.
   assign o_fpshift = i_shift_en && (r_ph >= PH_RISE) && (r_ph <= PH_FALL);

   assign o_ph   = r_ph;
   assign o_tick = w_tick;
   assign o_pidx = r_pidx;

endmodule

// File: rtl/stn_panel_tx.sv
// STN panel transmit driver: fetches a monochrome frame from the byte RAM
// (registered, one-cycle read latency) and serialises it as 4-bit nibbles
// with line/frame markers. Byte, address and line bookkeeping live here;
// shift timing comes from stn_shift_timer.
module stn_panel_tx
   import stn_pkg::*;
#(
   parameter int H_PIX    = 256,
   parameter int V_LINES  = 192,
   parameter int H_BLANK  = 8,
   parameter int LP_WIDTH = 2,
   parameter int DIV      = 4
)(
   input  logic                  clk,
   input  logic                  rst_x,
   input  logic                  en,
   output logic                  ram_ce,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   input  logic [7:0]            ram_rdata,
   output logic                  stn_fpframe,
   output logic                  stn_fpline,
   output logic                  stn_fpshift,
   output logic [STN_DAT_W-1:0]  stn_fpdat,
   output logic                  frame_end
);

   localparam int BYTES_PER_LINE = H_PIX / 8;
   localparam int ACT_PERIODS    = H_PIX / 4;
   localparam int MAX_PERIODS    = (ACT_PERIODS > H_BLANK) ? ACT_PERIODS : H_BLANK;
   localparam int PH_W           = cnt_w(2 * DIV);
   localparam int PIDX_W         = cnt_w(MAX_PERIODS);
   localparam int LINE_W         = cnt_w(V_LINES);

   localparam logic [PH_W-1:0]       PH_1          = PH_W'(1);
   localparam logic [PIDX_W-1:0]     PIDX_ACT_LAST = PIDX_W'(ACT_PERIODS - 1);
   localparam logic [PIDX_W-1:0]     PIDX_HB_LAST  = PIDX_W'(H_BLANK - 1);
   localparam logic [PIDX_W-1:0]     PIDX_LP       = PIDX_W'(LP_WIDTH);
   // Low-nibble periods below this index still have a following byte to fetch.
   localparam logic [PIDX_W-1:0]     PIDX_PF_LIM   = PIDX_W'(ACT_PERIODS - 2);
   localparam logic [LINE_W-1:0]     LINE_LAST     = LINE_W'(V_LINES - 1);
   localparam logic [RAM_ADDR_W-1:0] ADDR_LAST     = RAM_ADDR_W'(BYTES_PER_LINE * V_LINES - 1);

   stn_state_e r_state;
   stn_state_e w_state_nxt;

   logic [PH_W-1:0]       w_ph;
   logic                  w_tick;
   logic [PIDX_W-1:0]     w_pidx;
   logic                  w_tmr_clr;
   logic                  w_shift_en;

   logic [RAM_ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0]     r_line;
   logic [7:0]            r_nxt_byte;
   logic [7:0]            r_cur_byte;
   logic                  r_rd_pend;

   logic                  w_last_line;
   logic                  w_pf_done;
   logic                  w_act_end;
   logic                  w_line_end;
   logic                  w_hi_start;

   // ------------------------------------------------------------------
   // Shift timer
   // ------------------------------------------------------------------
   // Timer restarts on every state change so each state begins at ph=0,
   // period 0; it is held cleared while idle.
   assign w_tmr_clr  = (w_state_nxt != r_state) || (r_state == ST_IDLE);
   assign w_shift_en = (r_state == ST_ACTIVE);

   stn_shift_timer #(
      .DIV    (DIV),
      .PH_W   (PH_W),
      .PIDX_W (PIDX_W)
   ) u_timer (
      .clk        (clk),
      .rst_x      (rst_x),
      .i_clr      (w_tmr_clr),
      .i_shift_en (w_shift_en),
      .o_ph       (w_ph),
      .o_tick     (w_tick),
      .o_pidx     (w_pidx),
      .o_fpshift  (stn_fpshift)
   );

   // ------------------------------------------------------------------
   // Sequencing events
   // ------------------------------------------------------------------
   assign w_last_line = (r_line == LINE_LAST);
   // Second prefetch cycle: read data is on ram_rdata now.
   assign w_pf_done   = (r_state == ST_PREFETCH) && (w_ph == PH_1);
   assign w_act_end   = (r_state == ST_ACTIVE) && w_tick && (w_pidx == PIDX_ACT_LAST);
   assign w_line_end  = (r_state == ST_HBLANK) && w_tick && (w_pidx == PIDX_HB_LAST);
   // Edge into a high-nibble period: either after a low nibble mid-line or
   // from blanking into the next line.
   assign w_hi_start  = ((r_state == ST_ACTIVE) && w_tick && w_pidx[0] && !w_act_end)
                     || (w_line_end && !w_last_line);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   // State register.
   always_ff @(posedge clk) begin
      if (!rst_x) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; en only matters in IDLE and at the frame boundary.
   always_comb begin
      // NOTE: default first so no path through the case leaves it unassigned (no latch).
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (en) w_state_nxt = ST_PREFETCH;
         end
         ST_PREFETCH: begin
            if (w_pf_done) w_state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (w_act_end) w_state_nxt = ST_HBLANK;
         end
         ST_HBLANK: begin
            if (w_line_end) begin
               if (!w_last_line) w_state_nxt = ST_ACTIVE;
               else if (en)      w_state_nxt = ST_PREFETCH;
               else              w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode from state, phase, period index and line.
   always_comb begin
      ram_ce      = 1'b0;
      stn_fpline  = 1'b0;
      stn_fpframe = 1'b0;
      stn_fpdat   = '0;
      frame_end   = 1'b0;
      case (r_state)
         ST_PREFETCH: begin
            ram_ce = (w_ph == '0);
         end
         ST_ACTIVE: begin
            // Even periods carry the high nibble, odd periods the low nibble.
            stn_fpdat = w_pidx[0] ? r_cur_byte[3:0] : r_cur_byte[7:4];
            // Fetch the following byte early in the low-nibble period.
            ram_ce    = w_pidx[0] && (w_pidx < PIDX_PF_LIM) && (w_ph == PH_1);
         end
         ST_HBLANK: begin
            stn_fpline  = (w_pidx < PIDX_LP);
            stn_fpframe = stn_fpline && w_last_line;
            // First byte of the next line is fetched in the last blank period.
            ram_ce      = (w_pidx == PIDX_HB_LAST) && (w_ph == PH_1) && !w_last_line;
            frame_end   = w_line_end && w_last_line;
         end
         default: ;
      endcase
   end

   assign ram_addr = r_addr;

   // ------------------------------------------------------------------
   // Byte pipeline, RAM address and line counter
   // ------------------------------------------------------------------
   // nxt_byte captures every read one cycle after its strobe; cur_byte is
   // what is being shifted out. The initial prefetch has no spare cycle, so
   // cur_byte takes that byte straight from the RAM.
   always_ff @(posedge clk) begin
      if (!rst_x) begin
         r_rd_pend  <= 1'b0;
         r_nxt_byte <= '0;
         r_cur_byte <= '0;
         r_addr     <= '0;
         r_line     <= '0;
      end else begin
         r_rd_pend <= ram_ce;
         if (r_rd_pend) r_nxt_byte <= ram_rdata;

         if (w_pf_done)       r_cur_byte <= ram_rdata;
         else if (w_hi_start) r_cur_byte <= r_nxt_byte;

         // Address advances after each strobe and wraps after the last byte
         // of the frame, so it is already 0 for the next frame.
         if (ram_ce) r_addr <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;

         if (w_line_end) r_line <= w_last_line ? '0 : r_line + 1'b1;
      end
   end

endmodule

// File: tb/tb_stn_panel_tx.sv
// Self-checking bench for stn_panel_tx with a reduced geometry so several
// frames fit in a short run. A frame-position model predicts every output
// each cycle; a monitor adds hand-computed literal expectations.
module tb_stn_panel_tx;

   localparam int HP  = 32;
   localparam int VL  = 6;
   localparam int HB  = 4;
   localparam int LP  = 2;
   localparam int DV  = 4;

   localparam int BPL       = HP / 8;
   localparam int NBYTES    = BPL * VL;
   localparam int APER      = HP / 4;
   localparam int PER_CLK   = 2 * DV;
   localparam int LINE_CLK  = (APER + HB) * PER_CLK;
   localparam int FRAME_CLK = 2 + VL * LINE_CLK;

   typedef struct packed {
      logic        ce;
      logic [12:0] addr;
      logic        fr;
      logic        ln;
      logic        sh;
      logic [3:0]  dat;
      logic        fe;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_x = 1'b0;
   logic        en = 1'b1;
   logic        ram_ce;
   logic [12:0] ram_addr;
   logic [7:0]  ram_rdata = 8'h00;
   logic        stn_fpframe;
   logic        stn_fpline;
   logic        stn_fpshift;
   logic [3:0]  stn_fpdat;
   logic        frame_end;

   logic [7:0]  mem [NBYTES];

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_on   = 1'b0;

   // model state: running flag and clock index within the frame
   bit m_run = 1'b0;
   int m_c   = 0;

   // monitor state
   int         ce_cnt = 0, fr_cnt = 0, hi_len = 0, ln_len = 0, fall_n = 0, frames = 0;
   bit         prev_sh = 1'b0, prev_ln = 1'b0, after_fe = 1'b0;
   logic [3:0] falls [4];
   int         ce_log [$];

   always #5 clk = ~clk;

   stn_panel_tx #(
      .H_PIX    (HP),
      .V_LINES  (VL),
      .H_BLANK  (HB),
      .LP_WIDTH (LP),
      .DIV      (DV)
   ) dut (
      .clk         (clk),
      .rst_x       (rst_x),
      .en          (en),
      .ram_ce      (ram_ce),
      .ram_addr    (ram_addr),
      .ram_rdata   (ram_rdata),
      .stn_fpframe (stn_fpframe),
      .stn_fpline  (stn_fpline),
      .stn_fpshift (stn_fpshift),
      .stn_fpdat   (stn_fpdat),
      .frame_end   (frame_end)
   );

   // registered RAM, one-cycle read latency
   always @(posedge clk) begin
      if (ram_ce) ram_rdata <= (ram_addr < 13'(NBYTES)) ? mem[ram_addr] : 8'hEE;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs at clock c of a frame (c=0 is the first prefetch cycle).
   function automatic exp_t model_out(input bit run, input int c);
      exp_t       e;
      int         u, l, r, p, ph, b, q;
      logic [7:0] bv;
      e = '0;
      if (!run || c == 1) return e;
      if (c == 0) begin
         e.ce = 1'b1;
         return e;
      end
      u  = c - 2;
      l  = u / LINE_CLK;
      r  = u % LINE_CLK;
      p  = r / PER_CLK;
      ph = r % PER_CLK;
      if (p < APER) begin
         b     = p / 2;
         bv    = mem[l * BPL + b];
         e.dat = (p % 2 == 0) ? bv[7:4] : bv[3:0];
         e.sh  = (ph >= 1) && (ph <= DV);
         if ((p % 2 == 1) && (b < BPL - 1) && (ph == 1)) begin
            e.ce   = 1'b1;
            e.addr = 13'(l * BPL + b + 1);
         end
      end else begin
         q    = p - APER;
         e.ln = (q < LP);
         e.fr = e.ln && (l == VL - 1);
         if ((q == HB - 1) && (ph == 1) && (l < VL - 1)) begin
            e.ce   = 1'b1;
            e.addr = 13'((l + 1) * BPL);
         end
         e.fe = (l == VL - 1) && (q == HB - 1) && (ph == PER_CLK - 1);
      end
      return e;
   endfunction

   // model advance: en is looked at only when idle or at the frame boundary
   always @(posedge clk) begin
      if (!rst_x) begin
         m_run = 1'b0;
         m_c   = 0;
      end else if (!m_run) begin
         if (en) begin
            m_run = 1'b1;
            m_c   = 0;
         end
      end else if (m_c == FRAME_CLK - 1) begin
         if (en) m_c = 0;
         else    m_run = 1'b0;
      end else begin
         m_c++;
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      exp_t e;
      if (cmp_on) begin
         e = model_out(m_run, m_c);
         check("ram_ce", ram_ce, e.ce);
         if (e.ce || !m_run) check("ram_addr", ram_addr, e.addr);
         check("fpframe", stn_fpframe, e.fr);
         check("fpline", stn_fpline, e.ln);
         check("fpshift", stn_fpshift, e.sh);
         check("fpdat", stn_fpdat, e.dat);
         check("frame_end", frame_end, e.fe);
      end
   end

   // literal pulse-width / per-frame count monitor
   always @(negedge clk) begin
      if (!rst_x) begin
         ce_cnt = 0; fr_cnt = 0; hi_len = 0; ln_len = 0; fall_n = 0;
         prev_sh = 1'b0; prev_ln = 1'b0; after_fe = 1'b0;
         ce_log.delete();
      end else if (cmp_on) begin
         if (ram_ce) begin
            ce_cnt++;
            if (ce_log.size() < 8) ce_log.push_back(int'(ram_addr));
            if (after_fe) begin
               check("addr_after_frame_end", ram_addr, 0);
               after_fe = 1'b0;
            end
         end
         if (stn_fpframe) fr_cnt++;
         if (stn_fpshift) hi_len++;
         else if (prev_sh) begin
            check("fpshift_high_clks", hi_len, 4);
            if (fall_n < 4) begin
               falls[fall_n] = stn_fpdat;
               fall_n++;
            end
            hi_len = 0;
         end
         if (stn_fpline) ln_len++;
         else if (prev_ln) begin
            check("fpline_high_clks", ln_len, 16);
            ln_len = 0;
         end
         if (frame_end) begin
            check("frame_ce_pulses", ce_cnt, 24);
            check("frame_fpframe_clks", fr_cnt, 16);
            ce_cnt   = 0;
            fr_cnt   = 0;
            after_fe = 1'b1;
            frames++;
         end
         prev_sh = stn_fpshift;
         prev_ln = stn_fpline;
      end
   end

   initial begin
      int  f0;
      bit  hit;
      for (int i = 0; i < NBYTES; i++) mem[i] = 8'($urandom);
      mem[0] = 8'hA5;
      mem[1] = 8'h3C;
      rst_x = 1'b0;
      en    = 1'b1;

      // reset held for 5 clocks with en=1
      @(posedge clk); #1;
      cmp_on = 1'b1;
      repeat (4) step();
      @(negedge clk);
      check("reset_outputs_zero",
            {ram_ce, ram_addr, stn_fpframe, stn_fpline, stn_fpshift, stn_fpdat, frame_end}, 0);

      // release: prefetch strobe appears on the first cycle after
      step();
      rst_x = 1'b1;
      @(posedge clk); @(negedge clk);
      check("release_first_ce", ram_ce, 1);
      check("release_first_addr", ram_addr, 0);

      // two full frames with en held high
      repeat (2 * FRAME_CLK + 10) step();
      check("frames_after_two", frames, 2);
      check("nibble0", falls[0], 4'hA);
      check("nibble1", falls[1], 4'h5);
      check("nibble2", falls[2], 4'h3);
      check("nibble3", falls[3], 4'hC);
      check("ce_log_len", ce_log.size() >= 6, 1);
      if (ce_log.size() >= 6) begin
         check("line0_last_ce_addr", ce_log[3], 3);
         check("line1_prefetch_addr", ce_log[4], 4);
         check("line1_second_addr", ce_log[5], 5);
      end

      // random enable, including mid-frame toggles
      repeat (4 * FRAME_CLK) begin
         step();
         en = 1'($urandom_range(0, 1));
      end

      // drop en in line 3: frame must finish, then idle
      en  = 1'b1;
      hit = 1'b0;
      for (int k = 0; k < 2 * FRAME_CLK + 10; k++) begin
         if (m_run && m_c == 2 + 3 * LINE_CLK) begin
            hit = 1'b1;
            break;
         end
         step();
      end
      check("reach_line3", hit, 1);
      en  = 1'b0;
      f0  = frames;
      hit = 1'b0;
      for (int k = 0; k < FRAME_CLK + 10; k++) begin
         step();
         if (frames != f0) begin
            hit = 1'b1;
            break;
         end
      end
      check("frame_completes_after_en_drop", hit, 1);
      repeat (40) step();
      @(negedge clk);
      check("idle_outputs_zero",
            {ram_ce, ram_addr, stn_fpframe, stn_fpline, stn_fpshift, stn_fpdat, frame_end}, 0);
      step();
      en = 1'b1;
      @(posedge clk); @(negedge clk);
      check("reenable_first_ce", ram_ce, 1);
      check("reenable_first_addr", ram_addr, 0);

      // reset in the middle of byte 2 of line 3
      hit = 1'b0;
      for (int k = 0; k < 2 * FRAME_CLK + 10; k++) begin
         if (m_run && m_c == 2 + 3 * LINE_CLK + 4 * PER_CLK + 3) begin
            hit = 1'b1;
            break;
         end
         step();
      end
      check("reach_line3_byte2", hit, 1);
      rst_x = 1'b0;
      @(posedge clk); @(negedge clk);
      check("midline_reset_zero",
            {ram_ce, ram_addr, stn_fpframe, stn_fpline, stn_fpshift, stn_fpdat, frame_end}, 0);
      for (int i = 0; i < NBYTES; i++) mem[i] = 8'($urandom);
      step();
      step();
      rst_x = 1'b1;
      @(posedge clk); @(negedge clk);
      check("midline_release_ce", ram_ce, 1);
      check("midline_release_addr", ram_addr, 0);

      repeat (FRAME_CLK + 100) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
